apb3_master_arbiter: RTL and testbench

//  Shares one APB3 master port between NUM_REQ on-chip requesters. Each requester uses a simple

---
 rtl/apb3_master_arbiter_if.sv | 40 ++++
 rtl/apb3_master_arbiter.sv | 127 ++++++++++++
 tb/tb_apb3_master_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb3_master_arbiter_if.sv
// Requester command/response channels and APB3 master bus shared by the arbiter.
// The master modport is the arbiter side; the slave modport is the surrounding fabric.
interface apb3_master_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      rsp_slverr;
    logic                      rsp_timeout;
    logic                      PSEL;
    logic                      PENABLE;
    logic                      PWRITE;
    logic [ADDR_W-1:0]         PADDR;
    logic [DATA_W-1:0]         PWDATA;
    logic [DATA_W-1:0]         PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;
    logic                      PCLKG;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        input  PRDATA, PREADY, PSLVERR,
        output req_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PCLKG
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        output PRDATA, PREADY, PSLVERR,
        input  req_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PCLKG
    );
endinterface

// File: rtl/apb3_master_arbiter.sv
// Round-robin arbiter sharing one APB3 master port between NUM_REQ requesters.
// Commands are accepted in IDLE or on the closing ACCESS cycle, giving
// back-to-back transfers; a watchdog aborts an ACCESS phase that never sees PREADY.
module apb3_master_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    apb3_master_arbiter_if.master bus
);
    localparam int          IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int          WD_W    = $clog2(TIMEOUT);
    localparam int unsigned NREQ_U  = NUM_REQ;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  gnt_q;
    logic [IDX_W-1:0]  win_idx, cand;
    logic              win_found;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              tmo, done, arb_point, accept;

    logic              pwrite_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;
    logic              psel_q, penable_q, pclkg_q;
    logic [NUM_REQ-1:0] rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_slverr_q, rsp_timeout_q;

    // Round-robin search from ptr_q and accept decision at each arbitration point
    always_comb begin
        tmo       = (state_q == ACCESS) && !bus.PREADY && (wd_q == WD_LAST);
        done      = (state_q == ACCESS) && (bus.PREADY || tmo);
        arb_point = !PRESET && ((state_q == IDLE) || done);
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NREQ_U; k++) begin
            cand = IDX_W'((32'(ptr_q) + k) % NREQ_U);
            if (!win_found && bus.req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        accept        = arb_point && win_found;
        ptr_d         = IDX_W'((32'(win_idx) + 1) % NREQ_U);
        bus.req_ready = accept ? (NUM_REQ'(1) << win_idx) : '0;
    end

    // Next-state and watchdog update
    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        case (state_q)
            IDLE:    if (accept) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS: begin
                if (done) state_d = accept ? SETUP : IDLE;
                else      wd_d    = wd_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (state_d == SETUP) wd_d = '0;
    end

    // State, pointer and command capture on accept
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            wd_q     <= '0;
            gnt_q    <= '0;
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            if (accept) begin
                ptr_q    <= ptr_d;
                gnt_q    <= win_idx;
                pwrite_q <= bus.req_write[win_idx];
                paddr_q  <= bus.req_addr[32'(win_idx) * ADDR_W +: ADDR_W];
                pwdata_q <= bus.req_wdata[32'(win_idx) * DATA_W +: DATA_W];
            end
        end
    end

    // Registered APB control, clock-gate enable and one-cycle response pulse
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pclkg_q       <= 1'b0;
            rsp_valid_q   <= '0;
            rsp_rdata_q   <= '0;
            rsp_slverr_q  <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            psel_q        <= (state_d != IDLE);
            penable_q     <= (state_d == ACCESS);
            pclkg_q       <= (state_d != IDLE);
            rsp_valid_q   <= done ? (NUM_REQ'(1) << gnt_q) : '0;
            rsp_rdata_q   <= (done && !tmo && !pwrite_q) ? bus.PRDATA : '0;
            rsp_slverr_q  <= done && (tmo || bus.PSLVERR);
            rsp_timeout_q <= tmo;
        end
    end

    assign bus.PSEL        = psel_q;
    assign bus.PENABLE     = penable_q;
    assign bus.PWRITE      = pwrite_q;
    assign bus.PADDR       = paddr_q;
    assign bus.PWDATA      = pwdata_q;
    assign bus.PCLKG       = pclkg_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_slverr  = rsp_slverr_q;
    assign bus.rsp_timeout = rsp_timeout_q;
endmodule

// File: tb/tb_apb3_master_arbiter.sv
// Bench for apb3_master_arbiter: transaction-level reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_apb3_master_arbiter;
    localparam int N   = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 8;

    logic PCLK = 1'b0;
    logic PRESET;
    always #5 PCLK = ~PCLK;

    apb3_master_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    apb3_master_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int pready_wait = 0;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endfunction

    function automatic void fail_bound(string name);
        n_chk++;
        $display("FAIL %s: got no DUT event, expected one within the cycle bound", name);
    endfunction

    function automatic logic [127:0] all_outs();
        return 128'({bus.req_ready, bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PCLKG,
                     bus.PADDR, bus.PWDATA, bus.rsp_valid, bus.rsp_rdata,
                     bus.rsp_slverr, bus.rsp_timeout});
    endfunction

    function automatic int onehot_idx(logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Slave: each transfer gets pready_wait ACCESS cycles with PREADY low
    initial begin
        int acc_n;
        acc_n = 0;
        bus.PREADY = 1'b0;
        forever begin
            @(posedge PCLK); #1;
            if (bus.PSEL && bus.PENABLE) begin
                bus.PREADY = (acc_n >= pready_wait);
                acc_n++;
            end else begin
                bus.PREADY = 1'b1;
                acc_n = 0;
            end
        end
    end

    // Reference model: a transfer is busy from the cycle after acceptance;
    // age 0 is the address phase, age >= 1 are data-phase cycles.
    bit          m_busy;
    int          m_age, m_ptr, m_g;
    logic        m_wr;
    logic [31:0] m_addr, m_wdata, m_rd;
    logic [3:0]  m_rv;
    logic        m_err, m_to;

    always @(negedge PCLK) begin
        bit acc, tmo, fin;
        int w, j;
        logic [3:0] exp_ready;
        if (PRESET) begin
            chk("reset_outputs", all_outs(), '0);
            m_busy = 0; m_age = 0; m_ptr = 0; m_g = 0; m_wr = 0;
            m_addr = 0; m_wdata = 0; m_rv = 0; m_rd = 0; m_err = 0; m_to = 0;
        end else begin
            acc = m_busy && (m_age >= 1);
            tmo = acc && !bus.PREADY && ((m_age - 1) == TMO - 1);
            fin = acc && (bus.PREADY || tmo);
            w = -1;
            if (!m_busy || fin) begin
                for (int k = 0; k < N; k++) begin
                    j = (m_ptr + k) % N;
                    if (w < 0 && bus.req_valid[j]) w = j;
                end
            end
            exp_ready = (w >= 0) ? (4'b0001 << w) : 4'b0000;
            chk("req_ready",   bus.req_ready,   exp_ready);
            chk("PSEL",        bus.PSEL,        m_busy);
            chk("PENABLE",     bus.PENABLE,     acc);
            chk("PCLKG",       bus.PCLKG,       m_busy);
            chk("PWRITE",      bus.PWRITE,      m_wr);
            chk("PADDR",       bus.PADDR,       m_addr);
            chk("PWDATA",      bus.PWDATA,      m_wdata);
            chk("rsp_valid",   bus.rsp_valid,   m_rv);
            chk("rsp_rdata",   bus.rsp_rdata,   m_rd);
            chk("rsp_slverr",  bus.rsp_slverr,  m_err);
            chk("rsp_timeout", bus.rsp_timeout, m_to);
            if (fin) begin
                m_rv  = 4'b0001 << m_g;
                m_rd  = (tmo || m_wr) ? 32'h0 : bus.PRDATA;
                m_err = tmo ? 1'b1 : bus.PSLVERR;
                m_to  = tmo;
            end else begin
                m_rv = 0; m_rd = 0; m_err = 0; m_to = 0;
            end
            if (w >= 0) begin
                m_busy  = 1;
                m_age   = 0;
                m_g     = w;
                m_wr    = bus.req_write[w];
                m_addr  = bus.req_addr[w*AW +: AW];
                m_wdata = bus.req_wdata[w*DW +: DW];
                m_ptr   = (w + 1) % N;
            end else if (fin) begin
                m_busy = 0;
            end else if (m_busy) begin
                m_age++;
            end
        end
    end

    task automatic tick();
        @(posedge PCLK); #1;
    endtask

    task automatic set_req(int i, logic wr, logic [31:0] a, logic [31:0] d);
        bus.req_write[i]          = wr;
        bus.req_addr[i*AW +: AW]  = a;
        bus.req_wdata[i*DW +: DW] = d;
        bus.req_valid[i]          = 1'b1;
    endtask

    task automatic wait_grant(string name, int i);
        bit got;
        got = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge PCLK);
            if (bus.req_ready[i]) begin got = 1; break; end
        end
        tick();
        bus.req_valid[i] = 1'b0;
        if (!got) fail_bound(name);
    endtask

    task automatic wait_rsp(string name, output int acc, output int unstable,
                            output logic [31:0] a_acc, output logic [3:0] rv,
                            output logic [31:0] rd, output logic err,
                            output logic to, output logic psel_r);
        bit seen;
        logic [31:0] d0;
        seen = 0; acc = 0; unstable = 0; a_acc = 0; d0 = 0;
        rv = 0; rd = 0; err = 0; to = 0; psel_r = 1;
        for (int c = 0; c < 300; c++) begin
            @(negedge PCLK);
            if (bus.rsp_valid != 0) begin
                rv = bus.rsp_valid; rd = bus.rsp_rdata; err = bus.rsp_slverr;
                to = bus.rsp_timeout; psel_r = bus.PSEL; seen = 1;
                break;
            end
            if (bus.PSEL && bus.PENABLE) begin
                if (acc == 0) begin
                    a_acc = bus.PADDR; d0 = bus.PWDATA;
                end else if (bus.PADDR !== a_acc || bus.PWDATA !== d0) begin
                    unstable++;
                end
                acc++;
            end
        end
        if (!seen) fail_bound(name);
    endtask

    task automatic drain(string name);
        bit ok;
        ok = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge PCLK);
            if (!bus.PSEL && bus.rsp_valid == 0) begin ok = 1; break; end
        end
        if (!ok) fail_bound(name);
        tick();
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish, expected completion");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int g[5];
        int exp_g[5];
        int ng, drops, acc, unst;
        logic [31:0] a_acc, rd;
        logic [3:0] rv;
        logic err, to, psel_r;

        PRESET = 1'b1;
        bus.req_valid = '0; bus.req_write = '0;
        bus.req_addr  = '0; bus.req_wdata = '0;
        bus.PRDATA    = '0; bus.PSLVERR   = 1'b0;
        @(negedge PCLK);
        chk("reset_state", all_outs(), '0);
        tick(); tick();
        PRESET = 1'b0;

        // All four requesters held continuously: grants 0,1,2,3,0, PSEL never drops
        exp_g = '{0, 1, 2, 3, 0};
        pready_wait = 0;
        set_req(0, 1'b0, 32'h100, 32'h0);
        set_req(1, 1'b1, 32'h104, 32'h11);
        set_req(2, 1'b0, 32'h108, 32'h0);
        set_req(3, 1'b1, 32'h10C, 32'h33);
        ng = 0; drops = 0;
        for (int c = 0; c < 60 && ng < 5; c++) begin
            @(negedge PCLK);
            if (ng > 0 && !bus.PSEL) drops++;
            if (bus.req_ready != 0) begin
                g[ng] = onehot_idx(bus.req_ready);
                ng++;
            end
        end
        tick();
        bus.req_valid = '0;
        if (ng < 5) fail_bound("t2_grants");
        for (int k = 0; k < ng; k++) chk($sformatf("t2_grant%0d", k), g[k], exp_g[k]);
        chk("t2_psel_drops", drops, 0);
        drain("t2_drain");

        // Single zero-wait read from requester 0
        bus.PRDATA = 32'hDEADBEEF; bus.PSLVERR = 1'b0; pready_wait = 0;
        set_req(0, 1'b0, 32'h10, 32'h0);
        @(negedge PCLK);
        chk("t1_c0_ready", bus.req_ready, 4'b0001);
        tick();
        bus.req_valid[0] = 1'b0;
        @(negedge PCLK);
        chk("t1_c1_psel_pen", {bus.PSEL, bus.PENABLE}, 2'b10);
        chk("t1_c1_paddr", bus.PADDR, 32'h10);
        @(negedge PCLK);
        chk("t1_c2_psel_pen", {bus.PSEL, bus.PENABLE}, 2'b11);
        @(negedge PCLK);
        chk("t1_c3_rsp_valid", bus.rsp_valid, 4'b0001);
        chk("t1_c3_rsp_rdata", bus.rsp_rdata, 32'hDEADBEEF);
        chk("t1_c3_psel", bus.PSEL, 1'b0);
        drain("t1_drain");

        // Write from requester 2, three wait states, slave error
        bus.PRDATA = 32'hCAFEF00D; bus.PSLVERR = 1'b1; pready_wait = 3;
        set_req(2, 1'b1, 32'h2000_0040, 32'h1234_5678);
        wait_grant("t3_grant", 2);
        wait_rsp("t3_rsp", acc, unst, a_acc, rv, rd, err, to, psel_r);
        chk("t3_access_cycles", acc, 4);
        chk("t3_unstable", unst, 0);
        chk("t3_paddr", a_acc, 32'h2000_0040);
        chk("t3_rsp_valid", rv, 4'b0100);
        chk("t3_rsp_slverr", err, 1'b1);
        chk("t3_rsp_timeout", to, 1'b0);
        chk("t3_rsp_rdata", rd, 32'h0);
        drain("t3_drain");

        // Slave never ready: watchdog aborts after TMO ACCESS cycles
        bus.PRDATA = 32'hA5A5A5A5; bus.PSLVERR = 1'b0; pready_wait = 1000;
        set_req(1, 1'b0, 32'h44, 32'h0);
        wait_grant("t4_grant", 1);
        wait_rsp("t4_rsp", acc, unst, a_acc, rv, rd, err, to, psel_r);
        chk("t4_access_cycles", acc, 8);
        chk("t4_rsp_valid", rv, 4'b0010);
        chk("t4_rsp_timeout", to, 1'b1);
        chk("t4_rsp_slverr", err, 1'b1);
        chk("t4_rsp_rdata", rd, 32'h0);
        chk("t4_psel_dropped", psel_r, 1'b0);
        drain("t4_drain");

        // Reset during ACCESS: immediate clear, then arbitration restarts at pointer 0
        pready_wait = 1000;
        set_req(1, 1'b0, 32'h88, 32'h0);
        wait_grant("t5_grant_a", 1);
        for (int c = 0; c < 10; c++) begin
            @(negedge PCLK);
            if (bus.PENABLE) break;
        end
        tick(); tick();
        PRESET = 1'b1;
        #1;
        chk("t5_async_clear", all_outs(), '0);
        set_req(1, 1'b0, 32'h90, 32'h0);
        set_req(3, 1'b1, 32'h9C, 32'h77);
        pready_wait = 0;
        #1;
        chk("t5_ready_in_reset", bus.req_ready, 4'b0000);
        tick();
        PRESET = 1'b0;
        @(negedge PCLK);
        chk("t5_rr_from_ptr0", bus.req_ready, 4'b0010);
        chk("t5_no_rsp", bus.rsp_valid, 4'b0000);
        tick();
        bus.req_valid[1] = 1'b0;
        wait_grant("t5_grant_c", 3);
        drain("t5_drain");

        tick(); tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
